// File: rtl/pipe_hazard_ctl.sv
// Hazard and flush controller beside the ID stage: redirect flush sequencing,
// load-use bubble insertion, memory-wait freeze and saturating event counters.
module pipe_hazard_ctl #(
  parameter int FLUSH_CYCLES        = 2,
  parameter bit REDIRECT_ACTIVE_LOW = 1'b1,
  parameter int REG_AW              = 5,
  parameter int STAT_W              = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_in,
  input  logic              mem_busy,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              flushing,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] lu_cnt
);

  if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("pipe_hazard_ctl: FLUSH_CYCLES must be in 0..15");
  end

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [STAT_W-1:0] stat_reg  [2];
  logic [STAT_W-1:0] stat_next [2];
  logic [1:0]        stat_event;

  logic              redir;
  logic              luh;
  logic              flush_active;
  logic              stall_raw;
  logic              lu_event;
  logic [REG_AW-1:0] src      [2];
  logic [1:0]        src_used;
  logic [1:0]        src_hit;

  assign redir = REDIRECT_ACTIVE_LOW ? ~redirect_in : redirect_in;

  assign src[0]      = id_rs1;
  assign src[1]      = id_rs2;
  assign src_used[0] = id_rs1_used;
  assign src_used[1] = id_rs2_used;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_used[gi] & (src[gi] == ex_rd);
  end

  // x0 is never a real producer, so a load targeting it cannot cause a hazard.
  assign luh          = ex_mem_read & (ex_rd != '0) & (|src_hit);
  assign flush_active = (state_reg == S_FLUSH);
  assign stall_raw    = mem_busy | (luh & ~redir & ~flush_active);
  assign lu_event     = luh & ~mem_busy & ~redir & ~flush_active;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (redir) begin
      cnt_next   = FLUSH_LOAD;
      state_next = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
    end else if (state_reg == S_FLUSH && !mem_busy) begin
      cnt_next = cnt_reg - 4'd1;
      if (cnt_reg == 4'd1) begin
        state_next = S_IDLE;
      end
    end
  end

  assign stat_event[0] = stall_raw;
  assign stat_event[1] = lu_event;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    assign stat_next[gi] = (stat_event[gi] && stat_reg[gi] != '1)
                         ? stat_reg[gi] + STAT_W'(1) : stat_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      stat_reg[0] <= '0;
      stat_reg[1] <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      stat_reg[0] <= stat_next[0];
      stat_reg[1] <= stat_next[1];
    end
  end

  // Reset masks even the combinational terms so nothing leaks out mid-reset.
  assign pc_stall    = ~rst & stall_raw;
  assign if_id_stall = ~rst & stall_raw;
  assign if_id_flush = ~rst & (redir | flush_active);
  assign id_ex_flush = ~rst & (redir | flush_active | (luh & ~mem_busy));
  assign id_ex_stall = ~rst & mem_busy & ~redir;
  assign flushing    = ~rst & flush_active;
  assign stall_cnt   = rst ? '0 : stat_reg[0];
  assign lu_cnt      = rst ? '0 : stat_reg[1];

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: an active-low default instance and an active-high
// instance with 4-bit counters, both driven with the same logical redirect.
module tb_pipe_hazard_ctl;

  // Control vector bit order: pc_stall, if_id_stall, if_id_flush,
  // id_ex_stall, id_ex_flush, flushing.
  localparam logic [5:0] C_NONE       = 6'b000000;
  localparam logic [5:0] C_REDIR      = 6'b001010;
  localparam logic [5:0] C_FLUSH      = 6'b001011;
  localparam logic [5:0] C_LU         = 6'b110010;
  localparam logic [5:0] C_BUSY       = 6'b110100;
  localparam logic [5:0] C_BUSY_FLUSH = 6'b111111;
  localparam logic [5:0] C_REDIR_BUSY = 6'b111010;

  typedef struct {
    logic [5:0] ctl;
    int         stall;
    int         lu;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, redir, mem_busy, ex_mem_read, u1, u2;
  logic [4:0] ex_rd, rs1, rs2;
  logic       a_redirect_in;
  assign a_redirect_in = ~redir;

  logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall, a_id_ex_flush, a_flushing;
  logic        h_pc_stall, h_if_id_stall, h_if_id_flush, h_id_ex_stall, h_id_ex_flush, h_flushing;
  logic [15:0] a_stall, a_lu;
  logic [3:0]  h_stall, h_lu;
  logic [5:0]  a_ctl, h_ctl;

  assign a_ctl = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall, a_id_ex_flush, a_flushing};
  assign h_ctl = {h_pc_stall, h_if_id_stall, h_if_id_flush, h_id_ex_stall, h_id_ex_flush, h_flushing};

  pipe_hazard_ctl dut_a (
    .clk(clk), .rst(rst), .redirect_in(a_redirect_in), .mem_busy(mem_busy),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2),
    .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
    .id_ex_stall(a_id_ex_stall), .id_ex_flush(a_id_ex_flush), .flushing(a_flushing),
    .stall_cnt(a_stall), .lu_cnt(a_lu)
  );

  pipe_hazard_ctl #(
    .FLUSH_CYCLES(2), .REDIRECT_ACTIVE_LOW(1'b0), .REG_AW(5), .STAT_W(4)
  ) dut_h (
    .clk(clk), .rst(rst), .redirect_in(redir), .mem_busy(mem_busy),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2),
    .pc_stall(h_pc_stall), .if_id_stall(h_if_id_stall), .if_id_flush(h_if_id_flush),
    .id_ex_stall(h_id_ex_stall), .id_ex_flush(h_id_ex_flush), .flushing(h_flushing),
    .stall_cnt(h_stall), .lu_cnt(h_lu)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;
  int   exp_lu    = 0;

  function automatic logic [3:0] sat4(input int x);
    return (x > 15) ? 4'hF : 4'(x);
  endfunction

  // Operand modes: 0 no load, 1 rs2 hit, 2 rd=x0, 3 rs1 hit, 4 match but unused.
  task automatic set_operands(input int mode);
    ex_mem_read = (mode != 0);
    case (mode)
      1:       begin ex_rd = 5; rs1 = 3; u1 = 1; rs2 = 5; u2 = 1; end
      2:       begin ex_rd = 0; rs1 = 0; u1 = 1; rs2 = 0; u2 = 1; end
      3:       begin ex_rd = 7; rs1 = 7; u1 = 1; rs2 = 2; u2 = 1; end
      4:       begin ex_rd = 7; rs1 = 7; u1 = 0; rs2 = 7; u2 = 0; end
      default: begin ex_rd = 5; rs1 = 5; u1 = 1; rs2 = 5; u2 = 1; end
    endcase
  endtask

  // Drive one cycle, queue what the outputs must be, and stop at the negedge.
  task automatic step(input logic r, input logic rd, input logic b, input int mode,
                      input logic [5:0] ectl);
    exp_t e;
    @(posedge clk); #1;
    rst = r; redir = rd; mem_busy = b;
    set_operands(mode);
    if (r) begin
      exp_stall = 0;
      exp_lu    = 0;
    end
    e.ctl = ectl; e.stall = exp_stall; e.lu = exp_lu;
    sb.push_back(e);
    if (!r && ectl[5]) exp_stall++;
    if (!r && ectl[5] && ectl[1] && !ectl[3]) exp_lu++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1; redir = 0; mem_busy = 0;
    set_operands(0);
    @(posedge clk); #1;
    exp_stall = 0;
    exp_lu    = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [5:0] tbl [8];
    tbl = '{C_NONE, C_NONE, C_NONE, C_NONE, C_REDIR, C_FLUSH, C_FLUSH, C_NONE};
    for (int i = 0; i < 8; i++) begin
      step(i < 4, (i < 5), (i == 3), (i == 3) ? 1 : 0, tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl})
        $display("FAIL reset[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      else $display("ok   reset[%0d] ctl=%b", i, e.ctl);
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) n_fail++;
      n_checks++;
      if ({a_stall, a_lu, h_stall, h_lu} !== {16'(e.stall), 16'(e.lu), sat4(e.stall), sat4(e.lu)}) begin
        n_fail++;
        $display("FAIL reset[%0d] counters: got a=%0d/%0d h=%0d/%0d want %0d/%0d",
                 i, a_stall, a_lu, h_stall, h_lu, e.stall, e.lu);
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, (i == 0), 0, 0, (i == 0) ? C_REDIR : (i < 3) ? C_FLUSH : C_NONE);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL redirect[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   redirect[%0d] ctl=%b", i, e.ctl);
      n_checks++;
      if ({a_stall, h_stall} !== {16'd0, 4'd0}) begin
        n_fail++;
        $display("FAIL redirect[%0d] stall_cnt: got a=%0d h=%0d want 0", i, a_stall, h_stall);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] rd_pat = 6'b000101;
    logic [5:0] tbl [6];
    tbl = '{C_REDIR, C_FLUSH, C_FLUSH, C_FLUSH, C_FLUSH, C_NONE};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, rd_pat[i], 0, 0, tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   back_to_back[%0d] ctl=%b", i, e.ctl);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    int modes [7];
    logic [5:0] tbl [7];
    modes = '{1, 0, 2, 3, 4, 0, 0};
    tbl   = '{C_LU, C_NONE, C_NONE, C_LU, C_NONE, C_NONE, C_NONE};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, modes[i], tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL load_use[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   load_use[%0d] mode=%0d ctl=%b lu=%0d", i, modes[i], e.ctl, e.lu);
      n_checks++;
      if ({a_stall, a_lu, h_stall, h_lu} !== {16'(e.stall), 16'(e.lu), sat4(e.stall), sat4(e.lu)}) begin
        n_fail++;
        $display("FAIL load_use[%0d] counters: got a=%0d/%0d h=%0d/%0d want %0d/%0d",
                 i, a_stall, a_lu, h_stall, h_lu, e.stall, e.lu);
      end
    end
  endtask

  task automatic test_freeze_flush();
    exp_t e;
    logic [9:0] rd_pat = 10'b0001000001;
    logic [9:0] b_pat  = 10'b0001000110;
    logic [5:0] tbl [10];
    tbl = '{C_REDIR, C_BUSY_FLUSH, C_BUSY_FLUSH, C_FLUSH, C_FLUSH, C_NONE,
            C_REDIR_BUSY, C_FLUSH, C_FLUSH, C_NONE};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, rd_pat[i], b_pat[i], 0, tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL freeze_flush[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   freeze_flush[%0d] ctl=%b", i, e.ctl);
      n_checks++;
      if ({a_stall, h_stall} !== {16'(e.stall), sat4(e.stall)}) begin
        n_fail++;
        $display("FAIL freeze_flush[%0d] stall_cnt: got a=%0d h=%0d want %0d",
                 i, a_stall, h_stall, e.stall);
      end
    end
  endtask

  task automatic test_squash_luh();
    exp_t e;
    logic [7:0] rd_pat = 8'b00001000;
    logic [7:0] b_pat  = 8'b00000001;
    int modes [8];
    logic [5:0] tbl [8];
    modes = '{1, 1, 0, 1, 1, 3, 0, 0};
    tbl   = '{C_BUSY, C_LU, C_NONE, C_REDIR, C_FLUSH, C_FLUSH, C_NONE, C_NONE};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, rd_pat[i], b_pat[i], modes[i], tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL squash_luh[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   squash_luh[%0d] ctl=%b lu=%0d", i, e.ctl, e.lu);
      n_checks++;
      if ({a_stall, a_lu, h_stall, h_lu} !== {16'(e.stall), 16'(e.lu), sat4(e.stall), sat4(e.lu)}) begin
        n_fail++;
        $display("FAIL squash_luh[%0d] counters: got a=%0d/%0d h=%0d/%0d want %0d/%0d",
                 i, a_stall, a_lu, h_stall, h_lu, e.stall, e.lu);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e;
    logic [5:0] tbl [5];
    tbl = '{C_REDIR, C_FLUSH, C_NONE, C_NONE, C_NONE};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step((i == 2), (i == 0), 0, 0, tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL reset_mid_flush[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end else $display("ok   reset_mid_flush[%0d] ctl=%b", i, e.ctl);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      step(0, 0, (i < 20), 0, (i < 20) ? C_BUSY : C_NONE);
      e = sb.pop_front();
      n_checks++;
      if ({a_ctl, h_ctl} !== {e.ctl, e.ctl}) begin
        n_fail++;
        $display("FAIL saturation[%0d] ctl: got a=%b h=%b want %b", i, a_ctl, h_ctl, e.ctl);
      end
      n_checks++;
      if ({a_stall, h_stall} !== {16'(e.stall), sat4(e.stall)}) begin
        n_fail++;
        $display("FAIL saturation[%0d] stall_cnt: got a=%0d h=%0d want %0d/%0d",
                 i, a_stall, h_stall, e.stall, sat4(e.stall));
      end else $display("ok   saturation[%0d] stall_cnt a=%0d h=%0d", i, a_stall, h_stall);
    end
  endtask

  initial begin
    rst = 1; redir = 0; mem_busy = 0;
    set_operands(0);
    test_reset();
    test_redirect();
    test_back_to_back();
    test_load_use();
    test_freeze_flush();
    test_squash_luh();
    test_reset_mid_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Parametrised hazard and flush controller for the five-stage RISC-V pipeline. It generalises the fixed three-cycle branch stall into four functions:
- a configurable-depth redirect flush sequencer;
- load-use hazard detection with a one-bubble stall;
- a global freeze input for multi-cycle memory waits;
- saturating performance counters.

It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register enables and flushes.

## Interface
- FLUSH_CYCLES, 2: bubble cycles after the redirect cycle (0–15).
- REDIRECT_ACTIVE_LOW, 1: 1 = `redirect_in` low means a taken branch or jump (matches `pc_sel` usage); 0 = active-high.
- REG_AW, 5: register-index width.
- STAT_W, 16: performance-counter width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_in  in  1  taken branch/jump from EX; polarity set by REDIRECT_ACTIVE_LOW.
- mem_busy  in  1  data/instruction memory not ready; freezes the whole pipe.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads rs1 / rs2.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_stall  out  1  hold the ID/EX register.
- id_ex_flush  out  1  load a bubble into ID/EX.
- flushing  out  1  registered: flush sequencer is in FLUSH.
- stall_cnt  out  STAT_W  cycles in which pc_stall was 1; saturating.
- lu_cnt  out  STAT_W  load-use bubbles inserted; saturating.

## Operation
- Definitions:
  - `redir = REDIRECT_ACTIVE_LOW ? ~redirect_in : redirect_in`.
  - `luh = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Flush FSM states:
  - IDLE: `cnt = 0`.
  - FLUSH: `cnt` in 1..FLUSH_CYCLES.
- FSM transitions:
  - `redir` in any state: `cnt <= FLUSH_CYCLES`; state becomes FLUSH if FLUSH_CYCLES > 0, otherwise stays IDLE. A redirect during FLUSH restarts the count.
  - FLUSH with no `redir` and `mem_busy = 1`: hold `cnt`.
  - FLUSH with no `redir` and `mem_busy = 0`: `cnt <= cnt - 1`; when `cnt == 1`, go to IDLE.
- Combinational outputs, applied in priority order (redirect > freeze > load-use):
  - `if_id_flush = redir | flushing`.
  - `id_ex_flush = redir | flushing | (luh & ~mem_busy)`.
  - `pc_stall = if_id_stall = mem_busy | (luh & ~redir & ~flushing)`.
  - `id_ex_stall = mem_busy & ~redir`.
- Load-use hazards seen while `redir` or `flushing` is 1 are ignored: the ID instruction is being squashed.
- While `rst = 1`, every output is forced to 0, including the combinational terms.
- Counters:
  - `stall_cnt` increments each cycle `pc_stall = 1`.
  - `lu_cnt` increments each cycle `luh & ~mem_busy & ~redir & ~flushing`.
  - Both saturate at all-ones; they never wrap.
- Width rule: `cnt` is 4 bits. FLUSH_CYCLES > 15 is illegal and flagged by an elaboration-time check.

## Timing
- Reset values: `cnt = 0`, state IDLE, `flushing = 0`, `stall_cnt = 0`, `lu_cnt = 0`; all outputs 0.
- Reset mid-FLUSH: the sequencer is IDLE on the next edge and no residual flush is issued.
- Redirect sampled high in cycle T (no `mem_busy`):
  - flush asserted combinationally in T;
  - `flushing = 1` in T+1 .. T+FLUSH_CYCLES;
  - `flushing = 0` in T+FLUSH_CYCLES+1.
- `mem_busy` during FLUSH extends the flush window by the number of busy cycles.
- Load-use: a one-cycle stall of PC and IF/ID plus one ID/EX bubble. The next cycle `luh` is 0 because the load has advanced to MEM.
- `mem_busy` plus `luh`: the pipe freezes with no bubble. The bubble is inserted in the first non-busy cycle if `luh` still holds.
- Simultaneous `redir` and `mem_busy`: the flush wins. ID/EX is flushed, not held, and PC is stalled.
- Counter latency: counters reflect a cycle's event on the following edge.

## Test plan
- Reset: hold `rst` 3 cycles with `redirect_in = 0` (active-low redirect) → all outputs 0 and counters 0 throughout. After release, default parameters → `if_id_flush = 1` in the first cycle and `flushing = 1` for the following 2 cycles.
- Redirect, FLUSH_CYCLES = 2, active-high: pulse `redir` in cycle 10 → `if_id_flush` and `id_ex_flush` high in cycles 10–12, low in cycle 13; `stall_cnt` stays 0.
- Back-to-back redirect: `redir` in cycles 10 and 12 → `flushing` high in cycles 11–14, low in cycle 15.
- Load-use: `ex_mem_read = 1`, `ex_rd = 5`, `id_rs2 = 5`, `id_rs2_used = 1` for one cycle → `pc_stall`, `if_id_stall` and `id_ex_flush` all 1 that cycle, and `lu_cnt` increments. Repeat with `ex_rd = 0` → no stall.
- Freeze plus flush: `redir` in cycle 10, `mem_busy` high in cycles 11–12 → `flushing` high in cycles 11–14. During busy cycles `id_ex_stall = 1` and `pc_stall = 1`.
- Saturation with STAT_W = 4: hold `mem_busy` 20 cycles → `stall_cnt` reaches 15 and stays at 15.
